vshift_seq: RTL and testbench

- Sequencer for the vector unit's serial bit-shifter; executes one vector shift instruction element by element.
- Per element: reads the element from the vector register file, starts the serial shifter, and waits out its stall.
- The serial shifter rotates rather than shifts, so this block masks and fills the rotated result before writing it back.
- Sits between vector issue and the shifter instance, and owns the shifter's start/operand ports.

---
 rtl/vshift_seq.sv | 142 ++++++++++++++
 tb/tb_vshift_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vshift_seq.sv
// vshift_seq: sequences one vector shift instruction through a serial
// rotating shifter, one element at a time. For each element it reads the
// register file, launches the shifter, waits out its stall and writes back
// the rotated result after masking/filling it into a true shift.
//
// Optional build macro VSHIFT_SEQ_VECSA_EN: adds elem_sa_data, a per-element
// shift amount read alongside elem_rd_data; in_sa is then ignored.
//
// Handshake: an instruction transfers on a rising clk edge where in_valid
// and in_ready are both high; in_ready is high only in IDLE, so in_valid
// while busy is ignored and the requester holds the instruction until taken.
module vshift_seq #(
  parameter int WIDTH = 32,
  parameter int VLW   = 6,
  parameter int SAW   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [VLW-1:0]   in_vl,
  input  logic [SAW-1:0]   in_sa,
  output logic [VLW-1:0]   elem_rd_addr,
  input  logic [WIDTH-1:0] elem_rd_data,
`ifdef VSHIFT_SEQ_VECSA_EN
  input  logic [SAW-1:0]   elem_sa_data,
`endif
  output logic [WIDTH-1:0] sh_opB,
  output logic [SAW-1:0]   sh_sa,
  output logic [1:0]       sh_op,
  output logic             sh_start,
  input  logic             sh_stalled,
  input  logic [WIDTH-1:0] sh_result,
  output logic             wb_en,
  output logic [VLW-1:0]   wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [VLW-1:0]   idx;
  logic [VLW-1:0]   vl_q;
  logic [1:0]       op_q;
  logic [SAW-1:0]   sa_q;
  logic [WIDTH-1:0] opb_q;
  logic             accept;
  logic             last_elem;
  logic             elem_done;
  logic [WIDTH-1:0] fixed;

  assign accept    = in_valid && (state == ST_IDLE);
  // Terminating on vl-1 means idx never has to represent vl itself.
  assign last_elem = (idx == (vl_q - {{(VLW-1){1'b0}}, 1'b1}));
  assign elem_done = (state == ST_WAIT) && !sh_stalled;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = (in_vl == '0) ? ST_DONE : ST_READ;
      ST_READ:  state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (!sh_stalled) state_nxt = last_elem ? ST_DONE : ST_READ;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Instruction fields, element index and the held shifter operand.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx   <= '0;
      vl_q  <= '0;
      op_q  <= '0;
      sa_q  <= '0;
      opb_q <= '0;
    end else begin
      if (accept) begin
        op_q <= in_op;
        vl_q <= in_vl;
        idx  <= '0;
`ifndef VSHIFT_SEQ_VECSA_EN
        sa_q <= in_sa;
`endif
      end
      if (state == ST_START) begin
        opb_q <= elem_rd_data;
`ifdef VSHIFT_SEQ_VECSA_EN
        sa_q  <= elem_sa_data;
`endif
      end
      if (elem_done && !last_elem) idx <= idx + {{(VLW-1){1'b0}}, 1'b1};
    end
  end

`ifdef VSHIFT_SEQ_VECSA_EN
  // in_sa is superseded by the per-element amount in this build.
  logic unused_in_sa;
  assign unused_in_sa = ^in_sa;
`endif

  // Turn the rotated result into a shift: op_q[0] is direction (1 = right),
  // op_q[1] is sign extension and only matters for right shifts.
  always_comb begin
    fixed = sh_result;
    if (!op_q[0]) begin
      fixed = sh_result & ({WIDTH{1'b1}} << sa_q);
    end else if (op_q[1] && opb_q[WIDTH-1]) begin
      fixed = sh_result | ~({WIDTH{1'b1}} >> sa_q);
    end else begin
      fixed = sh_result & ({WIDTH{1'b1}} >> sa_q);
    end
  end

  assign in_ready     = (state == ST_IDLE);
  assign elem_rd_addr = idx;
  assign sh_opB       = opb_q;
  assign sh_sa        = sa_q;
  assign sh_op        = op_q;
  assign sh_start     = (state == ST_START);
  assign wb_en        = elem_done;
  assign wb_addr      = idx;
  assign wb_data      = elem_done ? fixed : '0;
  assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_vshift_seq.sv
// Testbench for vshift_seq: register-file and rotating-shifter models around
// the DUT, a driver that issues instructions, and a monitor that checks each
// writeback against an expected queue filled from a plain-arithmetic model.
module tb_vshift_seq;
  localparam int W   = 32;
  localparam int VLW = 6;
  localparam int SAW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_op;
  logic [VLW-1:0] in_vl;
  logic [SAW-1:0] in_sa;
  logic [VLW-1:0] elem_rd_addr;
  logic [W-1:0]   elem_rd_data;
`ifdef VSHIFT_SEQ_VECSA_EN
  logic [SAW-1:0] elem_sa_data;
`endif
  logic [W-1:0]   sh_opB;
  logic [SAW-1:0] sh_sa;
  logic [1:0]     sh_op;
  logic           sh_start;
  logic           sh_stalled;
  logic [W-1:0]   sh_result;
  logic           wb_en;
  logic [VLW-1:0] wb_addr;
  logic [W-1:0]   wb_data;
  logic           done;

  vshift_seq #(.WIDTH(W), .VLW(VLW), .SAW(SAW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_vl(in_vl), .in_sa(in_sa),
    .elem_rd_addr(elem_rd_addr), .elem_rd_data(elem_rd_data),
`ifdef VSHIFT_SEQ_VECSA_EN
    .elem_sa_data(elem_sa_data),
`endif
    .sh_opB(sh_opB), .sh_sa(sh_sa), .sh_op(sh_op), .sh_start(sh_start),
    .sh_stalled(sh_stalled), .sh_result(sh_result),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .done(done)
  );

  // ---------------- environment models ----------------
  logic [W-1:0]   mem    [0:63];
  logic [SAW-1:0] sa_mem [0:63];

  // Register file: data one cycle after address.
  always @(posedge clk) begin
    elem_rd_data <= mem[elem_rd_addr];
`ifdef VSHIFT_SEQ_VECSA_EN
    elem_sa_data <= sa_mem[elem_rd_addr];
`endif
  end

  // Serial rotator: stalls sh_sa cycles after the start pulse.
  logic pend;
  int   cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (sh_start) begin
      pend <= 1'b1;
      cnt  <= 0;
    end else if (pend) begin
      if (cnt >= int'(sh_sa)) pend <= 1'b0;
      else cnt <= cnt + 1;
    end
  end
  assign sh_stalled = pend && (cnt < int'(sh_sa));

  always_comb begin
    int s;
    s = int'(sh_sa);
    if (sh_op[0]) sh_result = (sh_opB >> s) | (sh_opB << (32 - s));
    else          sh_result = (sh_opB << s) | (sh_opB >> (32 - s));
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0]   exp_q[$];
  logic [VLW-1:0] exp_addr_q[$];
  int checks   = 0;
  int failures = 0;
  logic done_ok = 1'b0;

  function automatic logic [W-1:0] ref_shift(input logic [1:0] op, input logic [W-1:0] x,
                                             input int sa);
    if (!op[0])     return x << sa;
    else if (op[1]) return $unsigned($signed(x) >>> sa);
    else            return x >> sa;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per writeback; flags stray writebacks/dones.
  always @(negedge clk) begin
    if (resetn) begin
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb actual addr=%0d data=%h expected none", wb_addr, wb_data);
        end else begin
          logic [W-1:0]   e;
          logic [VLW-1:0] a;
          e = exp_q.pop_front();
          a = exp_addr_q.pop_front();
          chk("wb_data", 64'(wb_data), 64'(e));
          chk("wb_addr", 64'(wb_addr), 64'(a));
        end
      end
      if (done && !done_ok) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end
    end
  end

  // ---------------- driver ----------------
  task automatic fill_sa(input int sa);
    for (int i = 0; i < 64; i++) sa_mem[i] = SAW'(sa);
  endtask

  // Pushes expectations, issues the instruction, waits for done and checks
  // accept-to-done latency. hold keeps in_valid high while busy.
  task automatic run_instr(input logic [1:0] op, input int vl, input int sa, input bit hold);
    int exp_lat;
    int lat;
    int n;
    exp_lat = 1;
    for (int i = 0; i < vl; i++) begin
      int s;
`ifdef VSHIFT_SEQ_VECSA_EN
      s = int'(sa_mem[i]);
`else
      s = sa;
`endif
      exp_q.push_back(ref_shift(op, mem[i], s));
      exp_addr_q.push_back(VLW'(i));
      exp_lat += s + 3;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_vl    = VLW'(vl);
    in_sa    = SAW'(sa);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", 64'(in_ready), 64'(1));
    done_ok = 1'b1;
    lat = 0;
    while (lat < 5000) begin
      @(negedge clk);
      lat++;
      if (!hold) in_valid = 1'b0;
      if (done) break;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("all_wb_before_done", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1 done_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_after_done", 64'(in_ready), 64'(1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = '0;
      sa_mem[i] = '0;
    end
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_vl    = '0;
    in_sa    = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_wb_en", 64'(wb_en), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sh_start", 64'(sh_start), 64'(0));
    chk("rst_rd_addr", 64'(elem_rd_addr), 64'(0));
    resetn = 1'b1;
    @(negedge clk);

    // SLL, vl=1, sa=4 -> 0x000000F0, latency 8
    fill_sa(4);
    mem[0] = 32'h8000000F;
    run_instr(2'b00, 1, 4, 1'b0);
    // SRL, vl=2, sa=8 -> 0x00FF0000, 0x00123456, latency 23
    fill_sa(8);
    mem[0] = 32'hFF000001;
    mem[1] = 32'h12345678;
    run_instr(2'b01, 2, 8, 1'b0);
    // SRA sa=31 with negative and positive elements
    fill_sa(31);
    mem[0] = 32'h80000000;
    run_instr(2'b11, 1, 31, 1'b0);
    mem[0] = 32'h7FFFFFFF;
    run_instr(2'b11, 1, 31, 1'b0);
    // op 10 behaves as SLL
    fill_sa(3);
    mem[0] = 32'hF000000F;
    run_instr(2'b10, 1, 3, 1'b0);
    // sa=0 passthrough, vl=3
    fill_sa(0);
    mem[0] = 32'd1;
    mem[1] = 32'd2;
    mem[2] = 32'd3;
    run_instr(2'b01, 3, 0, 1'b0);
    // vl=0 with in_valid held, then vl=2 with in_valid held while busy
    run_instr(2'b00, 0, 5, 1'b1);
    fill_sa(2);
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h0F0F0F0F;
    run_instr(2'b11, 2, 2, 1'b1);
    // Long vector: 63 elements, idx reaches its maximum
    fill_sa(1);
    for (int i = 0; i < 63; i++) mem[i] = $urandom;
    run_instr(2'b11, 63, 1, 1'b0);

    // Randomized instructions
    for (int t = 0; t < 10; t++) begin
      int vl;
      int sa;
      vl = $urandom_range(1, 6);
      sa = $urandom_range(0, 31);
      for (int i = 0; i < 64; i++) begin
        mem[i]    = $urandom;
        sa_mem[i] = SAW'($urandom_range(0, 31));
      end
      run_instr(2'($urandom_range(0, 3)), vl, sa, 1'b0);
    end

    // Reset during WAIT of element 1 of a vl=4 instruction
    fill_sa(6);
    for (int i = 0; i < 4; i++) begin
      mem[i] = $urandom;
      exp_q.push_back(ref_shift(2'b01, mem[i], 6));
      exp_addr_q.push_back(VLW'(i));
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_vl    = VLW'(4);
    in_sa    = SAW'(6);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!wb_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("first_wb_seen", 64'(wb_en), 64'(1));
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_wb_en", 64'(wb_en), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_rd_addr", 64'(elem_rd_addr), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", 64'(in_ready), 64'(1));
    fill_sa(5);
    mem[0] = 32'h00000001;
    mem[1] = 32'h80000000;
    run_instr(2'b00, 2, 5, 1'b0);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
